chunk_writer: RTL

Sits directly downstream of the USB command stage. Each chunk_write_enable pulse captures the 32-bit chunk and its panel/row/chunk address into a small FIFO. A serializer then writes the chunk into the LED frame memory as eight 4-bit pixel writes. Memory-side backpressure is handled with mem_ready, and chunks that arrive while the FIFO is full are dropped and flagged.

---
 rtl/cube_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 37 +++
 rtl/chunk_writer.sv | 103 ++++++++++
 3 files changed

// File: rtl/cube_pkg.sv
// cube_pkg: shared widths, FIFO entry layout and serializer states for the LED cube datapath
package cube_pkg;
  localparam int PANEL_AW = 2;
  localparam int ROW_AW = 4;
  localparam int CHUNK_AW = 4;
  localparam int NIBBLE_AW = 3;
  localparam int PIXEL_W = 4;
  localparam int CHUNK_W = 32;
  localparam int MEM_AW = PANEL_AW + ROW_AW + CHUNK_AW + NIBBLE_AW;
  typedef struct packed {
    logic [PANEL_AW-1:0] panel;
    logic [ROW_AW-1:0] row;
    logic [CHUNK_AW-1:0] chunk;
    logic [CHUNK_W-1:0] data;
  } chunk_entry_t;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;
  function automatic logic [MEM_AW-1:0] mem_addr_of(chunk_entry_t e, logic [NIBBLE_AW-1:0] i);
    return {e.panel, e.row, e.chunk, i};
  endfunction
  function automatic logic [PIXEL_W-1:0] nibble_of(chunk_entry_t e, logic [NIBBLE_AW-1:0] i);
    return e.data[i*PIXEL_W +: PIXEL_W];
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data; writes when full and reads when empty are ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/chunk_writer.sv
// chunk_writer: buffers 32-bit chunks and serializes them into eight 4-bit frame-memory writes.
// Optional CHUNK_WRITER_DROP_COUNT_EN adds a saturating drop_count output.
module chunk_writer
  import cube_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NIBBLES = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHUNK_W-1:0]  chunk_data,
  input  logic [CHUNK_AW-1:0] chunk_addr,
  input  logic [ROW_AW-1:0]   row_addr,
  input  logic [PANEL_AW-1:0] panel_addr,
  input  logic                chunk_write_enable,
  input  logic                mem_ready,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [PIXEL_W-1:0]  mem_data,
  output logic                mem_write_enable,
  output logic                fifo_empty,
  output logic                busy,
  output logic                overflow,
  input  logic                clear_overflow
`ifdef CHUNK_WRITER_DROP_COUNT_EN
  ,output logic [7:0]         drop_count
`endif
);
  chunk_entry_t wr_entry, rd_entry, entry_q, entry_d;
  state_t state, state_d;
  logic [NIBBLE_AW-1:0] idx_q, idx_d, idx_inc;
  logic [MEM_AW-1:0] addr_d;
  logic [PIXEL_W-1:0] data_d;
  logic full, pop, drop, we_d;
  assign wr_entry = {panel_addr, row_addr, chunk_addr, chunk_data};
  assign drop = chunk_write_enable && full;
  assign busy = state != IDLE;
  assign idx_inc = idx_q + NIBBLE_AW'(1);
  sync_fifo #(.WIDTH($bits(chunk_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .wr_en(chunk_write_enable), .wr_data(wr_entry),
    .rd_en(pop), .rd_data(rd_entry), .full(full), .empty(fifo_empty)
  );
  // Outputs are computed one cycle ahead so mem_* come straight from flops
  always_comb begin
    state_d = state;
    entry_d = entry_q;
    idx_d = idx_q;
    pop = 1'b0;
    we_d = mem_write_enable;
    addr_d = mem_addr;
    data_d = mem_data;
    case (state)
      IDLE: begin
        pop = !fifo_empty;
        state_d = fifo_empty ? IDLE : LOAD;
      end
      LOAD: begin
        entry_d = rd_entry;
        idx_d = '0;
        state_d = WRITE;
        we_d = 1'b1;
        addr_d = mem_addr_of(rd_entry, '0);
        data_d = nibble_of(rd_entry, '0);
      end
      WRITE:
        if (mem_ready) begin
          if (idx_q == NIBBLE_AW'(NIBBLES-1)) begin
            we_d = 1'b0;
            pop = !fifo_empty;
            state_d = fifo_empty ? IDLE : LOAD;
          end else begin
            idx_d = idx_inc;
            addr_d = mem_addr_of(entry_q, idx_inc);
            data_d = nibble_of(entry_q, idx_inc);
          end
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      entry_q <= '0;
      idx_q <= '0;
      mem_write_enable <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_d;
      entry_q <= entry_d;
      idx_q <= idx_d;
      mem_write_enable <= we_d;
      mem_addr <= addr_d;
      mem_data <= data_d;
      overflow <= drop || (overflow && !clear_overflow);
    end
`ifdef CHUNK_WRITER_DROP_COUNT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) drop_count <= '0;
    else if (drop) drop_count <= (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;
    else if (clear_overflow) drop_count <= '0;
`endif
endmodule
